// File: rtl/dmem_arbiter.sv
`default_nettype none
// dmem_arbiter: two-port round-robin arbiter and access checker feeding a
// single-port byte-addressed data memory through a command and a response register.
module dmem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_0,
  output logic                  req_ready_1,
  input  logic                  req_we_0,
  input  logic                  req_we_1,
  input  logic [2:0]            req_func3_0,
  input  logic [2:0]            req_func3_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [DATA_WIDTH-1:0] req_wdata_0,
  input  logic [DATA_WIDTH-1:0] req_wdata_1,
  output logic                  rsp_valid_0,
  output logic                  rsp_valid_1,
  output logic                  rsp_err_0,
  output logic                  rsp_err_1,
  output logic [DATA_WIDTH-1:0] rsp_rdata_0,
  output logic [DATA_WIDTH-1:0] rsp_rdata_1,
  output logic                  mem_we,
  output logic [2:0]            mem_func3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = {{ADDR_WIDTH{1'b0}}, 1'b1} << MEM_ADDR_BITS;

  logic                  last_grant_q, last_grant_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_port_q, cmd_port_d;
  logic                  cmd_we_q, cmd_we_d;
  logic [2:0]            cmd_func3_q, cmd_func3_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_port_q, rsp_port_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  gnt0, gnt1, hs;
  logic                  sel_we;
  logic [2:0]            sel_func3;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [1:0]            last_off;
  logic                  illegal, misaligned, out_of_range;
  logic [ADDR_WIDTH:0]   end_addr;

  // last_grant_q==1 means port 1 was served last, so port 0 wins a tie.
  assign gnt0 = req_valid_0 & (~req_valid_1 | last_grant_q);
  assign gnt1 = req_valid_1 & ~gnt0;
  assign hs   = gnt0 | gnt1;
  assign req_ready_0 = gnt0;
  assign req_ready_1 = gnt1;

  assign sel_we    = gnt1 ? req_we_1    : req_we_0;
  assign sel_func3 = gnt1 ? req_func3_1 : req_func3_0;
  assign sel_addr  = gnt1 ? req_addr_1  : req_addr_0;
  assign sel_wdata = gnt1 ? req_wdata_1 : req_wdata_0;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    last_off   = 2'd0;
    case (sel_func3)
      3'd0, 3'd4: last_off = 2'd0;
      3'd1, 3'd5: begin
        last_off   = 2'd1;
        misaligned = sel_addr[0];
      end
      3'd2: begin
        last_off   = 2'd3;
        misaligned = |sel_addr[1:0];
      end
      default: illegal = 1'b1;
    endcase
    if (sel_we && sel_func3[2]) illegal = 1'b1;
    // One extra bit keeps addr+size-1 from wrapping at the top of the address space.
    end_addr     = {1'b0, sel_addr} + {{(ADDR_WIDTH-1){1'b0}}, last_off};
    out_of_range = (end_addr >= MEM_LIMIT);
  end

  always_comb begin
    last_grant_d = hs ? gnt1 : last_grant_q;
    cmd_valid_d  = hs;
    cmd_port_d   = hs ? gnt1      : cmd_port_q;
    cmd_we_d     = hs ? sel_we    : cmd_we_q;
    cmd_func3_d  = hs ? sel_func3 : cmd_func3_q;
    cmd_addr_d   = hs ? sel_addr  : cmd_addr_q;
    cmd_wdata_d  = hs ? sel_wdata : cmd_wdata_q;
    cmd_err_d    = hs ? (illegal | misaligned | out_of_range) : cmd_err_q;
    rsp_valid_d  = 1'b0;
    rsp_port_d   = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_rdata_d  = '0;
    if (cmd_valid_q) begin
      rsp_valid_d = 1'b1;
      rsp_port_d  = cmd_port_q;
      rsp_err_d   = cmd_err_q;
      rsp_rdata_d = (cmd_we_q | cmd_err_q) ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      cmd_valid_q  <= 1'b0;
      cmd_port_q   <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_func3_q  <= 3'd0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_port_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_port_q   <= cmd_port_d;
      cmd_we_q     <= cmd_we_d;
      cmd_func3_q  <= cmd_func3_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_err_q    <= cmd_err_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_port_q   <= rsp_port_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign mem_we    = cmd_valid_q & cmd_we_q & ~cmd_err_q;
  assign mem_func3 = cmd_valid_q ? cmd_func3_q : 3'd0;
  assign mem_addr  = cmd_valid_q ? cmd_addr_q  : '0;
  assign mem_wdata = cmd_valid_q ? cmd_wdata_q : '0;

  assign rsp_valid_0 = rsp_valid_q & ~rsp_port_q;
  assign rsp_valid_1 = rsp_valid_q &  rsp_port_q;
  assign rsp_err_0   = rsp_valid_0 & rsp_err_q;
  assign rsp_err_1   = rsp_valid_1 & rsp_err_q;
  assign rsp_rdata_0 = rsp_valid_0 ? rsp_rdata_q : '0;
  assign rsp_rdata_1 = rsp_valid_1 ? rsp_rdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// tb_dmem_arbiter: directed stimulus with a scoreboard queue of expected responses
// and an independent response monitor; includes a byte-addressed memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_0 = 0, req_valid_1 = 0;
  logic        req_ready_0, req_ready_1;
  logic        req_we_0 = 0, req_we_1 = 0;
  logic [2:0]  req_func3_0 = 0, req_func3_1 = 0;
  logic [31:0] req_addr_0 = 0, req_addr_1 = 0;
  logic [31:0] req_wdata_0 = 0, req_wdata_1 = 0;
  logic        rsp_valid_0, rsp_valid_1, rsp_err_0, rsp_err_1;
  logic [31:0] rsp_rdata_0, rsp_rdata_1;
  logic        mem_we;
  logic [2:0]  mem_func3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_we_0(req_we_0), .req_we_1(req_we_1),
    .req_func3_0(req_func3_0), .req_func3_1(req_func3_1),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_err_0(rsp_err_0), .rsp_err_1(rsp_err_1),
    .rsp_rdata_0(rsp_rdata_0), .rsp_rdata_1(rsp_rdata_1),
    .mem_we(mem_we), .mem_func3(mem_func3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, combinational read with size/sign handling.
  logic [7:0]  mem [0:131071];
  logic        mem_clr = 1'b1;
  logic [16:0] ma0, ma1, ma2, ma3;
  assign ma0 = mem_addr[16:0];
  assign ma1 = ma0 + 17'd1;
  assign ma2 = ma0 + 17'd2;
  assign ma3 = ma0 + 17'd3;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 131072; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[ma0] <= mem_wdata[7:0];
      if (mem_func3[1:0] != 2'd0) mem[ma1] <= mem_wdata[15:8];
      if (mem_func3[1:0] == 2'd2) begin
        mem[ma2] <= mem_wdata[23:16];
        mem[ma3] <= mem_wdata[31:24];
      end
    end
  end

  always_comb begin
    mem_rdata = 32'h0;
    case (mem_func3)
      3'd0: mem_rdata = {{24{mem[ma0][7]}}, mem[ma0]};
      3'd4: mem_rdata = {24'h0, mem[ma0]};
      3'd1: mem_rdata = {{16{mem[ma1][7]}}, mem[ma1], mem[ma0]};
      3'd5: mem_rdata = {16'h0, mem[ma1], mem[ma0]};
      3'd2: mem_rdata = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
      default: mem_rdata = 32'h0;
    endcase
  end

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   err_phase = 0;
  int   we_in_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (err_phase && mem_we) we_in_err++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon_port(input bit p, input logic err, input logic [31:0] rd);
    exp_t e;
    if (q.size() == 0) begin
      chk($sformatf("unexpected_rsp_port%0d", p), 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk("rsp_port", {31'h0, p}, {31'h0, e.port});
      chk("rsp_err", {31'h0, err}, {31'h0, e.err});
      chk("rsp_rdata", rd, e.rdata);
      chk("rsp_cycle", cyc, e.cyc);
    end
  endtask

  // Response monitor: decoupled from stimulus, checks against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid_0 && rsp_valid_1) chk("rsp_both_valid", 32'd1, 32'd0);
      if (rsp_valid_0) mon_port(1'b0, rsp_err_0, rsp_rdata_0);
      else chk("idle_rsp0", {rsp_err_0, rsp_rdata_0[30:0]}, 32'd0);
      if (rsp_valid_1) mon_port(1'b1, rsp_err_1, rsp_rdata_1);
      else chk("idle_rsp1", {rsp_err_1, rsp_rdata_1[30:0]}, 32'd0);
    end
  end

  task automatic set_req(input int p, input bit v, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      req_valid_0 = v; req_we_0 = we; req_func3_0 = f3; req_addr_0 = a; req_wdata_0 = wd;
    end else begin
      req_valid_1 = v; req_we_1 = we; req_func3_1 = f3; req_addr_1 = a; req_wdata_1 = wd;
    end
  endtask

  task automatic push_exp(input int p, input bit eerr, input logic [31:0] erd);
    exp_t e;
    e.port  = (p != 0);
    e.err   = eerr;
    e.rdata = erd;
    e.cyc   = cyc + 2;
    q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the edge that ends the handshake cycle.
  task automatic issue(input int p, input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit eerr, input logic [31:0] erd,
                       input bit push);
    bit got = 0;
    set_req(p, 1'b1, we, f3, a, wd);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if ((p == 0) ? req_ready_0 : req_ready_1) begin
        got = 1;
        if (push) push_exp(p, eerr, erd);
      end
    end
    chk($sformatf("handshake_p%0d_%h", p, a), {31'h0, got}, 32'd1);
    @(posedge clk); #1;
    set_req(p, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [2:0]  c_f3 [2][2];
  logic [31:0] c_ad [2][2];
  logic [31:0] c_ex [2][2];

  initial begin
    int i0, i1, g;
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_rsp", {28'h0, rsp_valid_0, rsp_valid_1, rsp_err_0, rsp_err_1}, 32'd0);
    chk("reset_rdata", rsp_rdata_0 | rsp_rdata_1, 32'd0);
    chk("reset_mem_ctl", {28'h0, mem_we, mem_func3}, 32'd0);
    chk("reset_mem_addr", mem_addr | mem_wdata, 32'd0);
    chk("reset_ready", {30'h0, req_ready_0, req_ready_1}, 32'd0);
    mem_clr = 1'b0;
    rst_n = 1'b1;
    step();

    // First store and its memory-side timing
    issue(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1);
    @(negedge clk);
    chk("sw_mem_we", {31'h0, mem_we}, 32'd1);
    chk("sw_mem_addr", mem_addr, 32'h10);
    chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_mem_func3", {29'h0, mem_func3}, 32'd2);
    step();

    // Load back with all widths
    issue(0, 0, 3'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1);
    issue(0, 0, 3'd0, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 1);
    issue(0, 0, 3'd4, 32'h13, 32'h0, 0, 32'h000000DE, 1);
    issue(0, 0, 3'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1);
    issue(0, 0, 3'd1, 32'h12, 32'h0, 0, 32'hFFFFDEAD, 1);
    issue(0, 0, 3'd5, 32'h12, 32'h0, 0, 32'h0000DEAD, 1);

    // Back-to-back store then load
    issue(0, 1, 3'd2, 32'h20, 32'h12345678, 0, 32'h0, 1);
    issue(0, 0, 3'd2, 32'h20, 32'h0, 0, 32'h12345678, 1);

    // Port 1 alone twice in a row
    issue(1, 1, 3'd2, 32'h40, 32'hA5A5A5A5, 0, 32'h0, 1);
    issue(1, 0, 3'd2, 32'h40, 32'h0, 0, 32'hA5A5A5A5, 1);

    // Contention: port 1 was served last, so grants run 0,1,0,1
    c_f3[0][0] = 3'd2; c_ad[0][0] = 32'h10; c_ex[0][0] = 32'hDEADBEEF;
    c_f3[0][1] = 3'd4; c_ad[0][1] = 32'h13; c_ex[0][1] = 32'h000000DE;
    c_f3[1][0] = 3'd2; c_ad[1][0] = 32'h40; c_ex[1][0] = 32'hA5A5A5A5;
    c_f3[1][1] = 3'd1; c_ad[1][1] = 32'h42; c_ex[1][1] = 32'hFFFFA5A5;
    i0 = 0; i1 = 0;
    set_req(0, 1, 0, c_f3[0][0], c_ad[0][0], 32'h0);
    set_req(1, 1, 0, c_f3[1][0], c_ad[1][0], 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      g = c % 2;
      chk($sformatf("contend_ready0_c%0d", c), {31'h0, req_ready_0}, (g == 0) ? 32'd1 : 32'd0);
      chk($sformatf("contend_ready1_c%0d", c), {31'h0, req_ready_1}, (g == 1) ? 32'd1 : 32'd0);
      if (req_ready_0 && i0 < 2) begin push_exp(0, 0, c_ex[0][i0]); i0++; end
      if (req_ready_1 && i1 < 2) begin push_exp(1, 0, c_ex[1][i1]); i1++; end
      @(posedge clk); #1;
      if (i0 >= 2) set_req(0, 0, 0, 3'd0, 32'h0, 32'h0);
      else set_req(0, 1, 0, c_f3[0][i0], c_ad[0][i0], 32'h0);
      if (i1 >= 2) set_req(1, 0, 0, 3'd0, 32'h0, 32'h0);
      else set_req(1, 1, 0, c_f3[1][i1], c_ad[1][i1], 32'h0);
    end
    set_req(0, 0, 0, 3'd0, 32'h0, 32'h0);
    set_req(1, 0, 0, 3'd0, 32'h0, 32'h0);
    step();

    // Error cases and legal accesses at the top of memory
    err_phase = 1;
    issue(0, 1, 3'd1, 32'h11, 32'h0000BBBB, 1, 32'h0, 1);
    issue(1, 0, 3'd2, 32'h02, 32'h0, 1, 32'h0, 1);
    issue(0, 1, 3'd4, 32'h50, 32'h000000FF, 1, 32'h0, 1);
    issue(1, 0, 3'd3, 32'h50, 32'h0, 1, 32'h0, 1);
    issue(0, 1, 3'd2, 32'h1FFFE, 32'h11223344, 1, 32'h0, 1);
    issue(1, 0, 3'd1, 32'h1FFFF, 32'h0, 1, 32'h0, 1);
    issue(0, 0, 3'd4, 32'h20000, 32'h0, 1, 32'h0, 1);
    issue(0, 0, 3'd5, 32'h1FFFF, 32'h0, 1, 32'h0, 1);
    issue(0, 0, 3'd2, 32'h1FFFC, 32'h0, 0, 32'h0, 1);
    issue(1, 0, 3'd0, 32'h1FFFF, 32'h0, 0, 32'h0, 1);
    step();
    err_phase = 0;
    chk("err_no_mem_we", we_in_err, 32'd0);
    issue(0, 0, 3'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1);
    issue(1, 0, 3'd2, 32'h50, 32'h0, 0, 32'h0, 1);
    issue(0, 0, 3'd2, 32'h1FFFC, 32'h0, 0, 32'h0, 1);
    repeat (4) step();

    // Reset during the access cycle of a store
    issue(0, 1, 3'd2, 32'h30, 32'hCAFEF00D, 0, 32'h0, 0);
    #1;
    chk("midrst_we_before", {31'h0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_we_after", {31'h0, mem_we}, 32'd0);
    chk("midrst_addr_after", mem_addr, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_rsp", {30'h0, rsp_valid_0, rsp_valid_1}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) step();
    issue(0, 0, 3'd2, 32'h30, 32'h0, 0, 32'h0, 1);
    issue(0, 0, 3'd2, 32'h20, 32'h0, 0, 32'h12345678, 1);

    for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
